// File: rtl/fft_pkg.sv
// Shared constants, read-side state encoding and the 5-bit index reversal
// used by the 32-point FFT output reorder block.
package fft_pkg;

  localparam int N      = 32;
  localparam int N_LOG2 = 5;
  localparam int DATA_W = 16;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  function automatic logic [N_LOG2-1:0] bitrev5(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = a[N_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: simple dual-port synchronous RAM holding {real, imag}
// per entry, one write port and one registered read port.
module fft_reorder_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [2*DATA_W-1:0]   rdata
);

  logic [2*DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array is deliberately left without a reset so it maps onto
  // block RAM; every entry is rewritten before a drain can ever read it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft32_reorder.sv
// Converts a bit-reversed 32-point FFT output stream into natural order using
// two ping-pong banks: one is filled while the other is drained.
module fft32_reorder #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N_LOG2 = fft_pkg::N_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_start,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [N_LOG2-1:0]        out_idx,
  output logic                     out_last,
  output logic                     frame_err
);

  import fft_pkg::rd_state_t;
  import fft_pkg::RD_IDLE;
  import fft_pkg::RD_DRAIN;
  import fft_pkg::bitrev5;

  localparam logic [N_LOG2-1:0] LAST_ADDR = '1;

  logic [N_LOG2-1:0]   wr_cnt, waddr;
  logic                wr_bank;
  logic                handoff;
  logic [N_LOG2-1:0]   rd_cnt, rd_cnt_nxt, raddr, rd_k;
  logic                rd_bank, rd_bank_nxt, rd_bank_d;
  logic                rd_en, rd_v;
  rd_state_t           state, state_nxt;
  logic [2*DATA_W-1:0] wdata, rdata0, rdata1, rdata;

  // A full frame is handed over only by a plain (non-start) sample at address 31.
  assign handoff = in_valid && !in_start && (wr_cnt == LAST_ADDR);
  assign waddr   = in_start ? '0 : wr_cnt;
  assign wdata   = {in_real, in_imag};

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= in_valid && in_start && (wr_cnt != '0);
      if (in_valid) begin
        wr_cnt <= in_start ? N_LOG2'(1) : wr_cnt + 1'b1;
        if (handoff) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  fft_reorder_bank #(.DATA_W(DATA_W), .ADDR_W(N_LOG2)) u_bank0 (
    .clk   (clk),
    .we    (in_valid && !wr_bank),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en && !rd_bank),
    .raddr (raddr),
    .rdata (rdata0)
  );

  fft_reorder_bank #(.DATA_W(DATA_W), .ADDR_W(N_LOG2)) u_bank1 (
    .clk   (clk),
    .we    (in_valid && wr_bank),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en && rd_bank),
    .raddr (raddr),
    .rdata (rdata1)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RD_IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    case (state)
      RD_IDLE: begin
        if (handoff) begin
          state_nxt   = RD_DRAIN;
          rd_cnt_nxt  = '0;
          rd_bank_nxt = wr_bank;
        end
      end
      RD_DRAIN: begin
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (rd_cnt == LAST_ADDR) begin
          // A hand-off on the final read restarts the drain with no gap.
          if (handoff) begin
            rd_bank_nxt = wr_bank;
          end else begin
            state_nxt = RD_IDLE;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == RD_DRAIN);
    raddr = bitrev5(rd_cnt);
  end

  // rd_bank may flip on the same edge as the last read, so the mux uses a delayed copy.
  assign rdata = rd_bank_d ? rdata1 : rdata0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_v      <= 1'b0;
      rd_k      <= '0;
      rd_bank_d <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_idx   <= '0;
    end else begin
      rd_v      <= rd_en;
      rd_k      <= rd_cnt;
      rd_bank_d <= rd_bank;
      out_valid <= rd_v;
      out_last  <= rd_v && (rd_k == LAST_ADDR);
      if (rd_v) begin
        out_real <= rdata[2*DATA_W-1:DATA_W];
        out_imag <= rdata[DATA_W-1:0];
        out_idx  <= rd_k;
      end else begin
        out_real <= '0;
        out_imag <= '0;
        out_idx  <= '0;
      end
    end
  end

endmodule

// File: doc/fft32_reorder.md
FFT32_REORDER -- requirements
Module: fft32_reorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of each real/imaginary component.
REQ-002 The block SHALL have parameter N_LOG2, default 5, giving log2 of the frame length (32 points).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the in_* sample is presented this cycle.
REQ-006 The block SHALL have port in_start, input, 1 bit: the in_* sample is the first of a frame; qualified by in_valid.
REQ-007 The block SHALL have ports in_real and in_imag, input, DATA_W bits each, signed: the FFT output sample, arriving in bit-reversed order.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_* carry a natural-order sample.
REQ-009 The block SHALL have ports out_real and out_imag, output, DATA_W bits each, signed: the reordered sample.
REQ-010 The block SHALL have port out_idx, output, N_LOG2 bits: natural frequency index k of the out_* sample.
REQ-011 The block SHALL have port out_last, output, 1 bit: high with k=31.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse flagging a discarded partial frame.

Function
REQ-013 The block SHALL contain two 32-entry banks of {real, imag} storage used ping-pong: one bank written while the other is read.
REQ-014 Write side: each accepted sample (in_valid=1) SHALL be written at address wr_cnt of the write bank, after which wr_cnt SHALL increment by 1 (mod 32).
REQ-015 An accepted sample with in_start=1 SHALL be written at address 0 and set wr_cnt to 1, whatever the current wr_cnt.
REQ-016 If in_start=1 is accepted while wr_cnt≠0, the partial frame SHALL be discarded and frame_err SHALL pulse high for exactly one cycle; the bank is not swapped.
REQ-017 When the sample at address 31 is accepted (edge E), the write bank SHALL become full, wr_bank SHALL toggle, and the full bank SHALL be handed to the read side.
REQ-018 The read side SHALL be a two-state FSM: IDLE, and DRAIN (rd_cnt 0..31).
REQ-019 IDLE SHALL go to DRAIN on a hand-off, with rd_cnt=0.
REQ-020 DRAIN SHALL perform one read per cycle at address bitrev5(rd_cnt) and increment rd_cnt.
REQ-021 After the read at rd_cnt=31, DRAIN SHALL go to IDLE, or stay in DRAIN with rd_cnt=0 if a hand-off occurs in that same cycle; this gives gapless back-to-back frames.
REQ-022 Read data SHALL be registered: out_valid, out_real, out_imag, out_idx=k and out_last SHALL appear one cycle after the read; the first out_valid is sampled at edge E+2.
REQ-023 out_valid SHALL be high for exactly 32 consecutive cycles per frame, with out_idx running 0..31 in order.
REQ-024 Outside a drain, out_valid and out_last SHALL be 0, and out_real, out_imag and out_idx SHALL hold 0.
REQ-025 With in_valid at most one sample per cycle, a hand-off SHALL never occur while a drain has more than one read remaining; no backpressure or overflow logic is required.
REQ-026 in_valid gaps SHALL be allowed anywhere in a frame; wr_cnt holds during a gap.
REQ-027 The block SHALL perform no arithmetic on the data: the output is bit-exact with the input at the mapped index.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL set all outputs to 0, wr_cnt=0, rd_cnt=0, wr_bank=0 and FSM=IDLE.
REQ-029 A reset mid-frame or mid-drain SHALL discard the partial frame and the remaining drain, with no further out_valid until a new full frame is written.
REQ-030 Bank contents SHALL NOT require reset.

Structure
REQ-031 Package fft_pkg SHALL hold N=32, N_LOG2=5, DATA_W=16 and the bitrev5 function.
REQ-032 The block SHALL use one sub-module, fft_reorder_bank: a 32x(2·DATA_W) single-write/single-read synchronous RAM, instanced twice.

Verification
REQ-033 Scenario 1: rst low for 2 cycles, then one frame with in_start at j=0, real=j, imag=-j -> out_valid starts at edge E+2, k=0:(0,0), k=1:(16,-16), k=2:(8,-8), k=31:(31,-31), out_last only at k=31.
REQ-034 Scenario 2: three frames back-to-back with no gaps, frame f values = 100f+j -> 96 contiguous out_valid cycles with correct bitrev values for each frame.
REQ-035 Scenario 3: in_start at j=20, then a full frame -> frame_err is one pulse, and only the full frame is output (32 outputs).
REQ-036 Scenario 4: a frame with in_valid toggled 1/0 -> output identical to scenario 1, starting at E+2 relative to the last accepted sample.
REQ-037 Scenario 5: rst asserted at k=10 of a drain -> out_valid=0 the next cycle and stays 0; a following frame reorders correctly.
REQ-038 Scenario 6: extreme values 0x7FFF/0x8000 -> passed through bit-exact.
